tank_ctrl: RTL
==============

TANK_CTRL -- requirements
Module: tank_ctrl

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- X_START 500, initial centre X; Y_START 200, initial centre Y.
- X_MIN 0, X_MAX 639, horizontal playfield limits.
- SIZE 4, tank half-size; STEP 1, pixels moved per frame.
- AIM_W 5, aim width; AIM_MAX 20, aim upper limit.
- AIM_RATE 4, frames per aim step while the key is held.
- AMMO_MAX 3, magazine size.
- COOLDOWN 8, frames after a shot before the next shot is allowed.
- RELOAD 60, frames for a full reload.
- KEY_LEFT 8'h0d, KEY_RIGHT 8'h0f, KEY_AIMUP 8'h0e, KEY_AIMDN 8'h0c, KEY_RELOAD 8'h13, KEY_FIRE 8'h28.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- frame_clk, in, 1: the only clock, one edge per video frame.
- Reset, in, 1: synchronous, active-high reset.
- keycode, in, 8: current key code (0 when no key is pressed).
- TankX, out, 10: centre X; TankY, out, 10: centre Y; TankS, out, 10: constant SIZE.
- Direction, out, 2: facing (0 = left, 1 = right).
- shoot, out, 1: one-frame fire pulse.
- aim, out, AIM_W: barrel elevation.
- ammo, out, $clog2(AMMO_MAX+1): rounds remaining.
- reloading, out, 1: high while the RELOAD state is active.

Function
REQ-003 All outputs SHALL be registered; an action caused by a keycode SHALL be visible one frame_clk edge after it is sampled.
REQ-004 On KEY_LEFT, TankX SHALL become max(TankX-STEP, X_MIN+SIZE) and Direction SHALL become 0; on KEY_RIGHT, TankX SHALL become min(TankX+STEP, X_MAX-SIZE) and Direction SHALL become 1; comparisons SHALL use 11-bit unsigned arithmetic with no wrap.
REQ-005 On any other keycode, TankX SHALL hold, and TankY SHALL never change after reset.
REQ-006 A free-running aim counter SHALL reset to 0 whenever keycode changes value.
REQ-007 While KEY_AIMUP is held, aim SHALL increment on the first frame and then every AIM_RATE frames, saturating at AIM_MAX.
REQ-008 KEY_AIMDN SHALL behave the same way, decrementing and saturating at 0.
REQ-009 Fire SHALL be edge-triggered: a fire request exists only on the frame where keycode==KEY_FIRE and the previous keycode was not KEY_FIRE.
REQ-010 The fire FSM SHALL have the states READY, COOLDOWN, RELOAD and EMPTY.
REQ-011 In READY, a fire request with ammo>0 SHALL pulse shoot for exactly one frame, decrement ammo, and go to COOLDOWN with the counter loaded to COOLDOWN-1.
REQ-012 In COOLDOWN, the counter SHALL decrement each frame.
REQ-013 When the COOLDOWN counter reaches 0, the FSM SHALL go to READY if ammo>0, otherwise to EMPTY.
REQ-014 Fire requests in COOLDOWN, RELOAD or EMPTY SHALL be ignored (no shoot pulse, no ammo change).
REQ-015 A KEY_RELOAD press edge in READY or EMPTY with ammo<AMMO_MAX SHALL go to RELOAD with the counter loaded to RELOAD-1 and assert reloading.
REQ-016 A KEY_RELOAD press edge in COOLDOWN, or with ammo==AMMO_MAX, SHALL be ignored.
REQ-017 In RELOAD, the counter SHALL decrement each frame; at 0, ammo SHALL become AMMO_MAX, reloading SHALL deassert and the FSM SHALL go to READY on the same edge.
REQ-018 Movement and aim SHALL remain active in every FSM state.
REQ-019 keycode is single-valued, so movement, aim and fire SHALL be mutually exclusive within one frame.

Reset
REQ-020 When Reset is sampled high, the block SHALL load TankX=X_START, TankY=Y_START, Direction=0, shoot=0, aim=0, ammo=AMMO_MAX, reloading=0, FSM=READY, counters=0 and previous-keycode=0.
REQ-021 Reset SHALL override every other action, including in mid-RELOAD or mid-COOLDOWN.

Structure
REQ-022 The fire-FSM state enum and the default key-code constants SHALL live in a shared package, tank_pkg.
REQ-023 The fire/reload FSM with its counter and ammo register SHALL be a sub-module, tank_weapon, instantiated by tank_ctrl.

Verification
REQ-024 Bench scenario, left clamp: reset with X_START=6, hold KEY_LEFT for 5 frames -> TankX sequence 5,4,4,4,4; Direction=0.
REQ-025 Bench scenario, aim saturation: hold KEY_AIMUP for 100 frames with AIM_RATE=4 -> aim reaches 20 at frame 77 and stays 20.
REQ-026 Bench scenario, held fire: hold KEY_FIRE for 30 frames -> exactly one shoot pulse, ammo 3->2.
REQ-027 Bench scenario, burst to EMPTY: issue 4 fire edges spaced 10 frames apart -> 3 pulses, ammo=0, FSM=EMPTY, 4th ignored.
REQ-028 Bench scenario, reload: from EMPTY press KEY_RELOAD -> reloading high for exactly 60 frames, ammo=3 on the 60th, then a fire edge produces a pulse.
REQ-029 Bench scenario, reset mid-operation: assert Reset at frame 30 of a reload -> next edge ammo=3, reloading=0, TankX=500, aim=0.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared definitions for the tank controller: weapon FSM states,
// default key codes and small elaboration-time helpers.
package tank_pkg;

  typedef enum logic [1:0] {
    ST_READY    = 2'd0,
    ST_COOLDOWN = 2'd1,
    ST_RELOAD   = 2'd2,
    ST_EMPTY    = 2'd3
  } weapon_state_e;

  localparam logic [7:0] KEY_LEFT_DEF   = 8'h0d;
  localparam logic [7:0] KEY_RIGHT_DEF  = 8'h0f;
  localparam logic [7:0] KEY_AIMUP_DEF  = 8'h0e;
  localparam logic [7:0] KEY_AIMDN_DEF  = 8'h0c;
  localparam logic [7:0] KEY_RELOAD_DEF = 8'h13;
  localparam logic [7:0] KEY_FIRE_DEF   = 8'h28;

  localparam logic [1:0] DIR_LEFT  = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tank_weapon.sv
// Fire/reload state machine: owns the magazine count, the shared
// cooldown/reload frame counter and the one-frame shoot pulse.
module tank_weapon
  import tank_pkg::*;
#(
  parameter int AMMO_MAX = 3,
  parameter int COOLDOWN = 8,
  parameter int RELOAD   = 60,
  localparam int AMMO_W  = $clog2(AMMO_MAX + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fire_req_i,
  input  logic              reload_req_i,
  output logic              shoot_o,
  output logic [AMMO_W-1:0] ammo_o,
  output logic              reloading_o
);

  localparam int CNT_W = $clog2(max2(COOLDOWN, RELOAD) + 1);

  localparam logic [CNT_W-1:0]  CD_LOAD   = CNT_W'(COOLDOWN - 1);
  localparam logic [CNT_W-1:0]  RL_LOAD   = CNT_W'(RELOAD - 1);
  localparam logic [AMMO_W-1:0] AMMO_FULL = AMMO_W'(AMMO_MAX);

  weapon_state_e     state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [AMMO_W-1:0] ammo_q;
  logic              shoot_q;
  logic              reloading_q;

  // NOTE: all state here updates with <= so every register sees the
  // pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_READY;
      cnt_q       <= '0;
      ammo_q      <= AMMO_FULL;
      shoot_q     <= 1'b0;
      reloading_q <= 1'b0;
    end else begin
      shoot_q <= 1'b0;
      case (state_q)
        ST_READY: begin
          if (fire_req_i && ammo_q != '0) begin
            shoot_q <= 1'b1;
            ammo_q  <= ammo_q - AMMO_W'(1);
            cnt_q   <= CD_LOAD;
            state_q <= ST_COOLDOWN;
          end else if (reload_req_i && ammo_q != AMMO_FULL) begin
            cnt_q       <= RL_LOAD;
            reloading_q <= 1'b1;
            state_q     <= ST_RELOAD;
          end
        end
        ST_COOLDOWN: begin
          // Requests are dropped here; only the countdown matters.
          if (cnt_q == '0) begin
            state_q <= (ammo_q != '0) ? ST_READY : ST_EMPTY;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RELOAD: begin
          if (cnt_q == '0) begin
            ammo_q      <= AMMO_FULL;
            reloading_q <= 1'b0;
            state_q     <= ST_READY;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_EMPTY: begin
          if (reload_req_i) begin
            cnt_q       <= RL_LOAD;
            reloading_q <= 1'b1;
            state_q     <= ST_RELOAD;
          end
        end
        default: state_q <= ST_READY;
      endcase
    end
  end

  assign shoot_o     = shoot_q;
  assign ammo_o      = ammo_q;
  assign reloading_o = reloading_q;

endmodule

// File: rtl/tank_ctrl.sv
// Player tank controller: keyboard-driven movement with edge clamping,
// rate-limited barrel aim, and an edge-triggered weapon sub-block.
module tank_ctrl
  import tank_pkg::*;
#(
  parameter int          X_START    = 500,
  parameter int          Y_START    = 200,
  parameter int          X_MIN      = 0,
  parameter int          X_MAX      = 639,
  parameter int          SIZE       = 4,
  parameter int          STEP       = 1,
  parameter int          AIM_W      = 5,
  parameter int          AIM_MAX    = 20,
  parameter int          AIM_RATE   = 4,
  parameter int          AMMO_MAX   = 3,
  parameter int          COOLDOWN   = 8,
  parameter int          RELOAD     = 60,
  parameter logic [7:0]  KEY_LEFT   = KEY_LEFT_DEF,
  parameter logic [7:0]  KEY_RIGHT  = KEY_RIGHT_DEF,
  parameter logic [7:0]  KEY_AIMUP  = KEY_AIMUP_DEF,
  parameter logic [7:0]  KEY_AIMDN  = KEY_AIMDN_DEF,
  parameter logic [7:0]  KEY_RELOAD = KEY_RELOAD_DEF,
  parameter logic [7:0]  KEY_FIRE   = KEY_FIRE_DEF,
  localparam int         AMMO_W     = $clog2(AMMO_MAX + 1)
) (
  input  logic              frame_clk,
  input  logic              Reset,
  input  logic [7:0]        keycode,
  output logic [9:0]        TankX,
  output logic [9:0]        TankY,
  output logic [9:0]        TankS,
  output logic [1:0]        Direction,
  output logic              shoot,
  output logic [AIM_W-1:0]  aim,
  output logic [AMMO_W-1:0] ammo,
  output logic              reloading
);

  localparam int AC_W = $clog2(AIM_RATE + 1);

  // Bounds are widened to 11 bits so neither step can wrap past 0 or 1023.
  localparam logic [10:0]      X_LO     = 11'(X_MIN + SIZE);
  localparam logic [10:0]      X_HI     = 11'(X_MAX - SIZE);
  localparam logic [10:0]      STEP_X   = 11'(STEP);
  localparam logic [AIM_W-1:0] AIM_TOP  = AIM_W'(AIM_MAX);
  localparam logic [AC_W-1:0]  AIM_WRAP = AC_W'(AIM_RATE);

  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q;
  logic [1:0]       dir_q, dir_d;
  logic [AIM_W-1:0] aim_q, aim_d;
  logic [AC_W-1:0]  aim_cnt_q, aim_cnt_d;
  logic [7:0]       prev_key_q;

  logic [10:0]     x_ext;
  logic [AC_W-1:0] aim_cnt_inc;
  logic            key_changed;
  logic            aim_tick;
  logic            fire_req;
  logic            reload_req;

  assign x_ext       = {1'b0, x_q};
  assign key_changed = (keycode != prev_key_q);
  assign aim_cnt_inc = aim_cnt_q + AC_W'(1);
  assign aim_tick    = key_changed || (aim_cnt_inc == AIM_WRAP);
  assign fire_req    = (keycode == KEY_FIRE)   && (prev_key_q != KEY_FIRE);
  assign reload_req  = (keycode == KEY_RELOAD) && (prev_key_q != KEY_RELOAD);

  // NOTE: every output of this block gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    x_d       = x_q;
    dir_d     = dir_q;
    aim_d     = aim_q;
    aim_cnt_d = aim_tick ? '0 : aim_cnt_inc;

    if (keycode == KEY_LEFT) begin
      x_d   = (x_ext < X_LO + STEP_X) ? X_LO[9:0] : 10'(x_ext - STEP_X);
      dir_d = DIR_LEFT;
    end else if (keycode == KEY_RIGHT) begin
      x_d   = (x_ext + STEP_X > X_HI) ? X_HI[9:0] : 10'(x_ext + STEP_X);
      dir_d = DIR_RIGHT;
    end else if (keycode == KEY_AIMUP) begin
      if (aim_tick && aim_q != AIM_TOP) aim_d = aim_q + AIM_W'(1);
    end else if (keycode == KEY_AIMDN) begin
      if (aim_tick && aim_q != '0) aim_d = aim_q - AIM_W'(1);
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      x_q        <= 10'(X_START);
      y_q        <= 10'(Y_START);
      dir_q      <= DIR_LEFT;
      aim_q      <= '0;
      aim_cnt_q  <= '0;
      prev_key_q <= '0;
    end else begin
      x_q        <= x_d;
      dir_q      <= dir_d;
      aim_q      <= aim_d;
      aim_cnt_q  <= aim_cnt_d;
      prev_key_q <= keycode;
    end
  end

  tank_weapon #(
    .AMMO_MAX (AMMO_MAX),
    .COOLDOWN (COOLDOWN),
    .RELOAD   (RELOAD)
  ) u_weapon (
    .clk_i        (frame_clk),
    .rst_i        (Reset),
    .fire_req_i   (fire_req),
    .reload_req_i (reload_req),
    .shoot_o      (shoot),
    .ammo_o       (ammo),
    .reloading_o  (reloading)
  );

  assign TankX     = x_q;
  assign TankY     = y_q;
  assign TankS     = 10'(SIZE);
  assign Direction = dir_q;
  assign aim       = aim_q;

endmodule
